dsi_fifo_wr_arbiter: RTL

Packet-granular round-robin arbiter that shares the single write port of the 256x32b sync FIFO between N_REQ pixel/command stream sources in the MIPI DSI colorbar path. It grants one requester at a time for a whole packet (valid/ready/last), forwards its beats into the FIFO under full back-pressure, and polices maximum packet length. It sits on the FIFO write-clock domain; the FIFO read side and the DSI packetizer are untouched.

---
 rtl/dsi_fifo_wr_arbiter_pkg.sv | 13 +
 rtl/dsi_fifo_wr_arbiter_if.sv | 23 ++
 rtl/dsi_fifo_wr_arbiter_rr_picker.sv | 26 ++
 rtl/dsi_fifo_wr_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/dsi_fifo_wr_arbiter_pkg.sv
// dsi_fifo_arb_pkg: shared FSM state type, tag constant and tag-word builder for the FIFO write arbiter.
package dsi_fifo_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} arb_state_e;

    localparam logic [7:0] TAG_MAGIC = 8'hA5;

    // Wide enough for any legal DATA_W; callers truncate to their beat width.
    function automatic logic [63:0] tag_word(input int data_w, input logic [7:0] id);
        return (64'(TAG_MAGIC) << (data_w - 8)) | 64'(id);
    endfunction

endpackage

// File: rtl/dsi_fifo_wr_arbiter_if.sv
// dsi_fifo_wr_arbiter_if: requester streams plus FIFO write port shared by the arbiter and its environment.
interface dsi_fifo_wr_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wr_data;
    logic                    fifo_wr_full;

    modport master (
        output req_valid, req_data, req_last, fifo_wr_full,
        input  req_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_wr_full,
        output req_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/dsi_fifo_wr_arbiter_rr_picker.sv
// dsi_rr_picker: combinational round-robin winner search starting one past ptr.
module dsi_rr_picker #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win,
    output logic             any
);
    int best;

    assign any = |req;

    // Distance from ptr+1 (mod N_REQ); the nearest active requester wins.
    always_comb begin
        best = N_REQ;
        win  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && ((i + N_REQ - 1 - int'(ptr)) % N_REQ) < best) begin
                best = (i + N_REQ - 1 - int'(ptr)) % N_REQ;
                win  = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/dsi_fifo_wr_arbiter.sv
// dsi_fifo_wr_arbiter: packet-granular round-robin arbiter feeding the sync FIFO write port.
// Define DSI_FIFO_ARB_TAG_EN to prefix every packet with a 0xA5/requester-id header word.
module dsi_fifo_wr_arbiter
    import dsi_fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 256,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    dsi_fifo_wr_arbiter_if.slave bus,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic                err_ovlen
);
`ifdef DSI_FIFO_ARB_TAG_EN
    localparam arb_state_e GRANT_ST = S_TAG;
`else
    localparam arb_state_e GRANT_ST = S_DATA;
`endif

    arb_state_e        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, win;
    logic              any_req, g_valid, g_last, accept, tag_wr, at_limit, pkt_end;
    logic [DATA_W-1:0] g_data, tag_data;
    logic [CNT_W-1:0]  beat_cnt;

    dsi_rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .win (win),
        .any (any_req)
    );

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept   = (state == S_DATA) && g_valid && !bus.fifo_wr_full;
`ifdef DSI_FIFO_ARB_TAG_EN
    assign tag_wr   = (state == S_TAG) && !bus.fifo_wr_full;
`else
    assign tag_wr   = 1'b0;
`endif
    assign tag_data = DATA_W'(tag_word(DATA_W, 8'(grant_id)));
    assign at_limit = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign pkt_end  = accept && (g_last || at_limit);
    assign busy     = (state != S_IDLE);

    // Write data is forced to zero whenever nothing is being written.
    always_comb begin
        bus.req_ready    = (state == S_DATA && !bus.fifo_wr_full) ? N_REQ'(1) << grant_id : '0;
        bus.fifo_wr_en   = accept | tag_wr;
        bus.fifo_wr_data = accept ? g_data : tag_wr ? tag_data : '0;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == S_IDLE) ? (any_req ? GRANT_ST : S_IDLE) :
                    (state == S_TAG)  ? (tag_wr ? S_DATA : S_TAG) :
                                        (pkt_end ? S_IDLE : S_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= ID_W'(N_REQ - 1);
            grant_id  <= '0;
            beat_cnt  <= '0;
            err_ovlen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req) begin
                grant_id <= win;
                rr_ptr   <= win;
            end
            if (accept)
                beat_cnt <= pkt_end ? '0 : beat_cnt + 1'b1;
            // Hitting the limit without last truncates the packet; the rest re-arbitrates.
            if (accept && !g_last && at_limit)
                err_ovlen <= 1'b1;
        end
    end
endmodule
